// File: rtl/wb_unit_pkg.sv
// Shared types and widths for the writeback unit: CSR op encodings,
// sequencer states and default bus widths.
package wb_unit_pkg;

  localparam int DATA_BUS_WIDTH = 32;
  localparam int REG_BUS_WIDTH  = 5;
  localparam int CSR_BUS_WIDTH  = 12;

  typedef enum logic [1:0] {
    CSR_OP_ILL = 2'b00,
    CSR_OP_RW  = 2'b01,
    CSR_OP_RS  = 2'b10,
    CSR_OP_RC  = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WB   = 2'd2
  } csr_st_e;

  // RS/RC with a zero source must leave the CSR untouched (no side effects).
  function automatic logic csr_writes(csr_op_e op, logic src_nz);
    case (op)
      CSR_OP_RW:            return 1'b1;
      CSR_OP_RS, CSR_OP_RC: return src_nz;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_unit_if.sv
// Result-source, CSR-port and GPR-port signals of the writeback unit.
// slave = the unit itself, master = the surrounding pipeline/regfile.
interface wb_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CSR_AW = 12
);
  logic              alu_vld_i;
  logic [REG_AW-1:0] alu_rd_i;
  logic [DATA_W-1:0] alu_data_i;

  logic              lsu_vld_i;
  logic              lsu_rdy_o;
  logic [REG_AW-1:0] lsu_rd_i;
  logic [DATA_W-1:0] lsu_data_i;

  logic              csr_vld_i;
  logic              csr_rdy_o;
  logic [1:0]        csr_op_i;
  logic [CSR_AW-1:0] csr_addr_i;
  logic [DATA_W-1:0] csr_src_i;
  logic [REG_AW-1:0] csr_rd_i;

  logic [CSR_AW-1:0] csr_raddr_o;
  logic [DATA_W-1:0] csr_rdata_i;
  logic [CSR_AW-1:0] csr_waddr_o;
  logic              csr_waddr_vld_o;
  logic [DATA_W-1:0] csr_wdata_o;

  logic [REG_AW-1:0] reg_waddr_o;
  logic              reg_waddr_vld_o;
  logic [DATA_W-1:0] reg_wdata_o;

  modport slave (
    input  alu_vld_i, alu_rd_i, alu_data_i,
    input  lsu_vld_i, lsu_rd_i, lsu_data_i,
    output lsu_rdy_o,
    input  csr_vld_i, csr_op_i, csr_addr_i, csr_src_i, csr_rd_i,
    output csr_rdy_o,
    output csr_raddr_o,
    input  csr_rdata_i,
    output csr_waddr_o, csr_waddr_vld_o, csr_wdata_o,
    output reg_waddr_o, reg_waddr_vld_o, reg_wdata_o
  );

  modport master (
    output alu_vld_i, alu_rd_i, alu_data_i,
    output lsu_vld_i, lsu_rd_i, lsu_data_i,
    input  lsu_rdy_o,
    output csr_vld_i, csr_op_i, csr_addr_i, csr_src_i, csr_rd_i,
    input  csr_rdy_o,
    input  csr_raddr_o,
    output csr_rdata_i,
    input  csr_waddr_o, csr_waddr_vld_o, csr_wdata_o,
    input  reg_waddr_o, reg_waddr_vld_o, reg_wdata_o
  );
endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with count-based full/empty; DEPTH must be a power of 2.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: arbitrates ALU, CSR-sequencer and LSU results onto the GPR
// write port and runs CSR read-modify-write sequences.
//
//   state   | meaning
//   IDLE    | ready for a CSR instruction, captures op/addr/src/rd
//   READ    | csr_raddr_o shows captured addr, old value is sampled
//   WB      | waits for the GPR port, then writes rd and the CSR together
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int DATA_W    = DATA_BUS_WIDTH,
  parameter int REG_AW    = REG_BUS_WIDTH,
  parameter int CSR_AW    = CSR_BUS_WIDTH,
  parameter int LSU_DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  wb_unit_if.slave  bus
);
  localparam int FW = REG_AW + DATA_W;

  csr_st_e           state_q, state_d;
  csr_op_e           op_q, op_d;
  logic [CSR_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [CSR_AW-1:0] csr_raddr_q, csr_raddr_d;
  logic [CSR_AW-1:0] csr_waddr_q, csr_waddr_d;
  logic              csr_wvld_q, csr_wvld_d;
  logic [DATA_W-1:0] csr_wdata_q, csr_wdata_d;
  logic [REG_AW-1:0] reg_waddr_q, reg_waddr_d;
  logic              reg_wvld_q, reg_wvld_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;

  logic              alu_win;
  logic [DATA_W-1:0] csr_new;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_head;
  logic [REG_AW-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  assign fifo_push = bus.lsu_vld_i && !fifo_full;
  assign head_rd   = fifo_head[DATA_W +: REG_AW];
  assign head_data = fifo_head[DATA_W-1:0];

  wb_fifo #(.DEPTH(LSU_DEPTH), .WIDTH(FW)) u_lsu_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (fifo_push),
    .wdata_i ({bus.lsu_rd_i, bus.lsu_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    case (op_q)
      CSR_OP_RW: csr_new = src_q;
      CSR_OP_RS: csr_new = old_q | src_q;
      CSR_OP_RC: csr_new = old_q & ~src_q;
      default:   csr_new = old_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    src_d       = src_q;
    rd_d        = rd_q;
    old_d       = old_q;
    csr_raddr_d = csr_raddr_q;
    csr_waddr_d = '0;
    csr_wvld_d  = 1'b0;
    csr_wdata_d = '0;
    reg_waddr_d = '0;
    reg_wvld_d  = 1'b0;
    reg_wdata_d = '0;
    fifo_pop    = 1'b0;

    // An x0 ALU result is dropped and leaves the port to the others.
    alu_win = bus.alu_vld_i && (bus.alu_rd_i != '0);
    if (alu_win) begin
      reg_wvld_d  = 1'b1;
      reg_waddr_d = bus.alu_rd_i;
      reg_wdata_d = bus.alu_data_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.csr_vld_i) begin
          op_d        = csr_op_e'(bus.csr_op_i);
          addr_d      = bus.csr_addr_i;
          src_d       = bus.csr_src_i;
          rd_d        = bus.csr_rd_i;
          csr_raddr_d = bus.csr_addr_i;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        old_d   = bus.csr_rdata_i;
        state_d = ST_WB;
      end
      ST_WB: begin
        if (!alu_win) begin
          if (rd_q != '0) begin
            reg_wvld_d  = 1'b1;
            reg_waddr_d = rd_q;
            reg_wdata_d = old_q;
          end
          if (csr_writes(op_q, src_q != '0)) begin
            csr_wvld_d  = 1'b1;
            csr_waddr_d = addr_q;
            csr_wdata_d = csr_new;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // x0 LSU entries retire without needing the port.
    if (!fifo_empty) begin
      if (head_rd == '0) begin
        fifo_pop = 1'b1;
      end else if (!alu_win && state_q != ST_WB) begin
        fifo_pop    = 1'b1;
        reg_wvld_d  = 1'b1;
        reg_waddr_d = head_rd;
        reg_wdata_d = head_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      op_q        <= CSR_OP_ILL;
      addr_q      <= '0;
      src_q       <= '0;
      rd_q        <= '0;
      old_q       <= '0;
      csr_raddr_q <= '0;
      csr_waddr_q <= '0;
      csr_wvld_q  <= 1'b0;
      csr_wdata_q <= '0;
      reg_waddr_q <= '0;
      reg_wvld_q  <= 1'b0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      src_q       <= src_d;
      rd_q        <= rd_d;
      old_q       <= old_d;
      csr_raddr_q <= csr_raddr_d;
      csr_waddr_q <= csr_waddr_d;
      csr_wvld_q  <= csr_wvld_d;
      csr_wdata_q <= csr_wdata_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wvld_q  <= reg_wvld_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign bus.lsu_rdy_o       = !fifo_full;
  assign bus.csr_rdy_o       = (state_q == ST_IDLE);
  assign bus.csr_raddr_o     = csr_raddr_q;
  assign bus.csr_waddr_o     = csr_waddr_q;
  assign bus.csr_waddr_vld_o = csr_wvld_q;
  assign bus.csr_wdata_o     = csr_wdata_q;
  assign bus.reg_waddr_o     = reg_waddr_q;
  assign bus.reg_waddr_vld_o = reg_wvld_q;
  assign bus.reg_wdata_o     = reg_wdata_q;

  a_lsu_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(bus.lsu_vld_i && fifo_full));

  a_csr_op_legal: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q == ST_IDLE && bus.csr_vld_i) |-> (bus.csr_op_i != 2'b00));

endmodule
